// File: rtl/hz_pkg.sv
// Shared types and sizing helpers for the hazard scoreboard and its match units.
package hz_pkg;

  // Widest register address an entry can hold; narrower RA_W values are zero-extended.
  localparam int RA_W_MAX = 8;

  localparam int FWD_RF = 0;

  typedef struct packed {
    logic                v;
    logic [RA_W_MAX-1:0] rd;
    logic                ld;
  } sb_entry_t;

  function automatic int fwd_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/hz_match.sv
// Priority search for one source operand: finds the youngest in-flight writer of
// src_i and reports whether its result is already forwardable.
module hz_match
  import hz_pkg::*;
#(
  parameter int RA_W     = 5,
  parameter int DEPTH    = 3,
  parameter int RDY_ALU  = 0,
  parameter int RDY_LOAD = 1
) (
  input  sb_entry_t [DEPTH-1:0]        entries_i,
  input  logic      [RA_W-1:0]         src_i,
  input  logic                         used_i,
  output logic                         hit_o,
  output logic                         ready_o,
  output logic      [idx_w(DEPTH)-1:0] idx_o
);

  localparam int IW = idx_w(DEPTH);

  // Scanning oldest to youngest lets the lowest matching index overwrite the result.
  always_comb begin
    hit_o   = 1'b0;
    ready_o = 1'b0;
    idx_o   = '0;
    if (used_i && (src_i != '0)) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (entries_i[k].v && (entries_i[k].rd == RA_W_MAX'(src_i))) begin
          hit_o   = 1'b1;
          idx_o   = IW'(k);
          ready_o = entries_i[k].ld ? (k >= RDY_LOAD) : (k >= RDY_ALU);
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard and forwarding controller built on a shift-register scoreboard
// of in-flight destination registers.
module hazard_scoreboard
  import hz_pkg::*;
#(
  parameter int RA_W     = 5,
  parameter int DEPTH    = 3,
  parameter int RDY_ALU  = 0,
  parameter int RDY_LOAD = 1,
  parameter int CNT_W    = 16
) (
  input  logic                        clock,
  input  logic                        reset_0,
  input  logic                        id_valid,
  input  logic [RA_W-1:0]             id_rs,
  input  logic [RA_W-1:0]             id_rt,
  input  logic                        id_rs_used,
  input  logic                        id_rt_used,
  input  logic [RA_W-1:0]             id_rd,
  input  logic                        id_wreg,
  input  logic                        id_is_load,
  input  logic                        flush,
  input  logic                        ex_busy,
  output logic                        stall,
  output logic                        issue,
  output logic [fwd_w(DEPTH)-1:0]     fwd_rs,
  output logic [fwd_w(DEPTH)-1:0]     fwd_rt,
  output logic [CNT_W-1:0]            stall_cnt
);

  localparam int FW = fwd_w(DEPTH);
  localparam int IW = idx_w(DEPTH);

  sb_entry_t [DEPTH-1:0] entries_q, entries_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

  logic          rs_hit, rs_ready, rt_hit, rt_ready, raw_haz;
  logic [IW-1:0] rs_idx, rt_idx;

  hz_match #(.RA_W(RA_W), .DEPTH(DEPTH), .RDY_ALU(RDY_ALU), .RDY_LOAD(RDY_LOAD)) u_match_rs (
    .entries_i (entries_q),
    .src_i     (id_rs),
    .used_i    (id_rs_used),
    .hit_o     (rs_hit),
    .ready_o   (rs_ready),
    .idx_o     (rs_idx)
  );

  hz_match #(.RA_W(RA_W), .DEPTH(DEPTH), .RDY_ALU(RDY_ALU), .RDY_LOAD(RDY_LOAD)) u_match_rt (
    .entries_i (entries_q),
    .src_i     (id_rt),
    .used_i    (id_rt_used),
    .hit_o     (rt_hit),
    .ready_o   (rt_ready),
    .idx_o     (rt_idx)
  );

  // Handshake with the ID stage: id_valid offers an instruction; it is taken into EX
  // at the next edge exactly when issue=1. stall=1 holds PC and IF/ID; flush wins over
  // both, so a flushed instruction neither stalls nor issues.
  always_comb begin
    raw_haz = id_valid && ((rs_hit && !rs_ready) || (rt_hit && !rt_ready));
    stall   = (raw_haz || ex_busy) && !flush;
    issue   = id_valid && !stall && !flush;
    fwd_rs  = (rs_hit && rs_ready) ? FW'(rs_idx) + FW'(1) : FW'(FWD_RF);
    fwd_rt  = (rt_hit && rt_ready) ? FW'(rt_idx) + FW'(1) : FW'(FWD_RF);
  end

  always_comb begin
    entries_d = entries_q;
    if (!ex_busy) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        entries_d[k] = entries_q[k-1];
      end
      // A stall, flush or write to r0 enters EX as a bubble.
      entries_d[0].v  = issue && id_wreg && (id_rd != '0);
      entries_d[0].rd = RA_W_MAX'(id_rd);
      entries_d[0].ld = id_is_load;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_0) begin
      entries_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      entries_q   <= entries_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed vector table, hand sequences
// for multi-cycle corners, and random stimulus against an age-list reference model.
module tb_hazard_scoreboard;
  import hz_pkg::*;

  localparam int RA_W     = 5;
  localparam int DEPTH    = 3;
  localparam int RDY_ALU  = 0;
  localparam int RDY_LOAD = 1;
  localparam int CNT_W    = 16;
  localparam int FW       = fwd_w(DEPTH);
  localparam int OW       = 2 + 2 * FW + CNT_W;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_0;
  always #5 clock = ~clock;

  logic            id_valid, id_rs_used, id_rt_used, id_wreg, id_is_load, flush, ex_busy;
  logic [RA_W-1:0] id_rs, id_rt, id_rd;
  logic            stall, issue, stall_b, issue_b;
  logic [FW-1:0]   fwd_rs, fwd_rt, fwd_rs_b, fwd_rt_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [3:0]      stall_cnt_b;

  hazard_scoreboard #(.RA_W(RA_W), .DEPTH(DEPTH), .RDY_ALU(RDY_ALU), .RDY_LOAD(RDY_LOAD),
                      .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_0(reset_0), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_wreg(id_wreg),
    .id_is_load(id_is_load), .flush(flush), .ex_busy(ex_busy), .stall(stall), .issue(issue),
    .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .stall_cnt(stall_cnt)
  );

  // Narrow-counter copy sharing all inputs, used to observe saturation.
  hazard_scoreboard #(.RA_W(RA_W), .DEPTH(DEPTH), .RDY_ALU(RDY_ALU), .RDY_LOAD(RDY_LOAD),
                      .CNT_W(4)) dut_sat (
    .clock(clock), .reset_0(reset_0), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_wreg(id_wreg),
    .id_is_load(id_is_load), .flush(flush), .ex_busy(ex_busy), .stall(stall_b),
    .issue(issue_b), .fwd_rs(fwd_rs_b), .fwd_rt(fwd_rt_b), .stall_cnt(stall_cnt_b)
  );

  // ---------------- reference model ----------------
  // In-flight writers as a list of {rd, load, age}; age counts post-ID stages travelled.
  typedef struct { int rd; bit ld; int age; } wr_t;
  wr_t wq[$];
  int  m_cnt = 0;

  typedef struct { bit hit; bit rdy; int age; } look_t;

  function automatic look_t lookup(input int src, input bit used);
    look_t r;
    r.hit = 0; r.rdy = 0; r.age = DEPTH;
    if (used && src != 0) begin
      foreach (wq[i]) begin
        if (wq[i].rd == src && wq[i].age < r.age) begin
          r.hit = 1;
          r.age = wq[i].age;
          r.rdy = (wq[i].age >= (wq[i].ld ? RDY_LOAD : RDY_ALU));
        end
      end
    end
    return r;
  endfunction

  function automatic void model_ctl(output bit m_stall, output bit m_issue,
                                    output int m_frs, output int m_frt);
    look_t a, b;
    bit haz;
    a = lookup(int'(id_rs), id_rs_used);
    b = lookup(int'(id_rt), id_rt_used);
    haz     = id_valid && ((a.hit && !a.rdy) || (b.hit && !b.rdy));
    m_stall = (haz || ex_busy) && !flush;
    m_issue = id_valid && !m_stall && !flush;
    m_frs   = (a.hit && a.rdy) ? a.age + 1 : 0;
    m_frt   = (b.hit && b.rdy) ? b.age + 1 : 0;
  endfunction

  function automatic logic [OW-1:0] model_out();
    bit s, i;
    int fa, fb;
    model_ctl(s, i, fa, fb);
    return {s, i, FW'(fa), FW'(fb), CNT_W'(m_cnt)};
  endfunction

  function automatic void model_update();
    bit s, i;
    int fa, fb;
    wr_t w;
    model_ctl(s, i, fa, fb);
    if (!reset_0) begin
      wq.delete();
      m_cnt = 0;
    end else begin
      if (s && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      if (!ex_busy) begin
        for (int k = wq.size() - 1; k >= 0; k--) begin
          wq[k].age++;
          if (wq[k].age >= DEPTH) wq.delete(k);
        end
        if (i && id_wreg && id_rd != 0) begin
          w.rd = int'(id_rd); w.ld = id_is_load; w.age = 0;
          wq.push_front(w);
        end
      end
    end
  endfunction

  // ---------------- scoreboard ----------------
  logic [OW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int v, rs, rt, rsu, rtu, rd, wreg, ld, fl, busy);
    id_valid   = 1'(v);
    id_rs      = RA_W'(rs);
    id_rt      = RA_W'(rt);
    id_rs_used = 1'(rsu);
    id_rt_used = 1'(rtu);
    id_rd      = RA_W'(rd);
    id_wreg    = 1'(wreg);
    id_is_load = 1'(ld);
    flush      = 1'(fl);
    ex_busy    = 1'(busy);
  endtask

  task automatic step_begin();
    logic [OW-1:0] e;
    int sat;
    exp_q.push_back(model_out());
    @(negedge clock);
    e = exp_q.pop_front();
    check("model_outputs", 64'({stall, issue, fwd_rs, fwd_rt, stall_cnt}), 64'(e));
    sat = (m_cnt > 15) ? 15 : m_cnt;
    check("narrow_instance", 64'({stall_b, issue_b, fwd_rs_b, fwd_rt_b, stall_cnt_b}),
          64'({e[OW-1:CNT_W], 4'(sat)}));
  endtask

  task automatic step_end();
    @(posedge clock);
    model_update();
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int v, rs, rt, rsu, rtu, rd, wreg, ld, fl, busy;
    int e_stall, e_issue, e_frs, e_frt, e_cnt;
  } vec_t;
  vec_t tbl[16];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    //          v rs rt su tu rd wr ld fl bz   st is fs ft cnt
    tbl[0]  = '{1, 1, 2, 1, 1, 5, 1, 0, 0, 0,  0, 1, 0, 0, 0};  // add r5
    tbl[1]  = '{1, 5, 6, 1, 1, 7, 1, 0, 0, 0,  0, 1, 1, 0, 0};  // back-to-back: EX fwd
    tbl[2]  = '{1, 5, 0, 1, 1, 0, 0, 0, 0, 0,  0, 1, 2, 0, 0};
    tbl[3]  = '{1, 5, 7, 1, 1, 0, 0, 0, 0, 0,  0, 1, 3, 2, 0};
    tbl[4]  = '{1, 5, 7, 1, 1, 0, 0, 0, 0, 0,  0, 1, 0, 3, 0};  // r5 retired
    tbl[5]  = '{1, 1, 0, 1, 0, 8, 1, 1, 0, 0,  0, 1, 0, 0, 0};  // lw r8
    tbl[6]  = '{1, 9, 8, 1, 1,10, 1, 0, 0, 0,  1, 0, 0, 0, 0};  // load-use stall
    tbl[7]  = '{1, 9, 8, 1, 1,10, 1, 0, 0, 0,  0, 1, 0, 2, 1};
    tbl[8]  = '{1,10, 0, 1, 0, 3, 1, 0, 0, 0,  0, 1, 1, 0, 1};
    tbl[9]  = '{1, 1, 2, 1, 1, 3, 1, 0, 0, 0,  0, 1, 0, 0, 1};
    tbl[10] = '{1, 3,10, 1, 1, 4, 1, 0, 0, 0,  0, 1, 1, 3, 1};  // youngest r3 wins
    tbl[11] = '{1, 0, 0, 1, 1, 0, 1, 0, 0, 0,  0, 1, 0, 0, 1};  // write to r0
    tbl[12] = '{1, 0, 4, 1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 1};  // r0 source, unused rt
    tbl[13] = '{1, 1, 2, 1, 1,12, 1, 1, 0, 0,  0, 1, 0, 0, 1};  // lw r12
    tbl[14] = '{1,12, 0, 1, 0,12, 1, 0, 1, 0,  0, 0, 0, 0, 1};  // flush beats hazard
    tbl[15] = '{1,12, 0, 1, 0, 0, 0, 0, 0, 0,  0, 1, 2, 0, 1};  // entry 0 was a bubble

    // Reset with garbage inputs for two edges.
    reset_0 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 31),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1));
      step_end();
    end
    reset_0 = 1'b1;
    drive(0, 3, 4, 1, 1, 0, 0, 0, 0, 0);
    step_begin();
    check("reset_stall", 64'(stall), 64'(0));
    check("reset_issue", 64'(issue), 64'(0));
    check("reset_fwd", 64'({fwd_rs, fwd_rt}), 64'(0));
    check("reset_cnt", 64'(stall_cnt), 64'(0));
    step_end();

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].rsu, tbl[i].rtu, tbl[i].rd,
            tbl[i].wreg, tbl[i].ld, tbl[i].fl, tbl[i].busy);
      step_begin();
      check($sformatf("vec%0d_stall", i), 64'(stall), 64'(tbl[i].e_stall));
      check($sformatf("vec%0d_issue", i), 64'(issue), 64'(tbl[i].e_issue));
      check($sformatf("vec%0d_fwd_rs", i), 64'(fwd_rs), 64'(tbl[i].e_frs));
      check($sformatf("vec%0d_fwd_rt", i), 64'(fwd_rt), 64'(tbl[i].e_frt));
      check($sformatf("vec%0d_cnt", i), 64'(stall_cnt), 64'(tbl[i].e_cnt));
      step_end();
    end

    // ex_busy freeze: r20 sits in EX while a dependent waits four cycles.
    drive(1, 1, 2, 1, 1, 20, 1, 0, 0, 0);
    step_begin(); step_end();
    for (int i = 0; i < 4; i++) begin
      drive(1, 20, 0, 1, 0, 22, 1, 0, 0, 1);
      step_begin();
      check("busy_stall", 64'(stall), 64'(1));
      check("busy_issue", 64'(issue), 64'(0));
      check("busy_fwd_frozen", 64'(fwd_rs), 64'(1));
      step_end();
    end
    drive(1, 20, 0, 1, 0, 22, 1, 0, 0, 0);
    step_begin();
    check("busy_release_issue", 64'(issue), 64'(1));
    check("busy_release_fwd", 64'(fwd_rs), 64'(1));
    check("busy_cnt_plus4", 64'(stall_cnt), 64'(5));
    step_end();

    // Mid-operation reset discards in-flight writers and the counter.
    drive(1, 1, 2, 1, 1, 21, 1, 0, 0, 0);
    step_begin(); step_end();
    reset_0 = 1'b0;
    drive(1, 21, 0, 1, 0, 0, 0, 0, 0, 0);
    step_begin(); step_end();
    reset_0 = 1'b1;
    step_begin();
    check("midreset_fwd", 64'(fwd_rs), 64'(0));
    check("midreset_issue", 64'(issue), 64'(1));
    check("midreset_cnt", 64'(stall_cnt), 64'(0));
    step_end();

    // Twenty busy cycles push the 4-bit counter past its ceiling.
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step_begin(); step_end();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step_begin();
    check("sat_narrow_cnt", 64'(stall_cnt_b), 64'(15));
    check("sat_wide_cnt", 64'(stall_cnt), 64'(20));
    step_end();

    // Random stimulus over a small register range to provoke frequent matches.
    for (int i = 0; i < 1500; i++) begin
      reset_0 = ($urandom_range(0, 99) != 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 6), $urandom_range(0, 6),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 6),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
      step_begin();
      step_end();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
